// File: rtl/isa_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction field positions and reset defaults.
// Imported by instruction_fetch and pc_next_sel.
package isa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // LABEL11 = instr[10:0], IMM8 = instr[7:0]; both are signed offsets from pc+1
  localparam int LABEL11_MSB = 10;
  localparam int IMM8_MSB    = 7;

  localparam logic [15:0] DEF_NOP_WORD = 16'h0000;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with the label/immediate sign-extend adders.
// Purely combinational: zero latency, no flow control.
module pc_next_sel
  import isa_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]    pc_plus1,
  input  logic [LABEL11_MSB:0] label11,
  input  logic [IMM8_MSB:0]    imm8,
  input  logic                 branch,
  input  logic                 jmp,
  input  logic                 flag_label_pc,
  input  logic                 flag_rm_pc,
  input  logic                 flag_rd_pc,
  input  logic [ADDR_W-1:0]    rm_data,
  input  logic [ADDR_W-1:0]    rd_data,
  output logic [ADDR_W-1:0]    next_pc
);

  logic [ADDR_W-1:0] label_ext;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] label_tgt;
  logic [ADDR_W-1:0] branch_tgt;

  assign label_ext  = {{(ADDR_W-LABEL11_MSB-1){label11[LABEL11_MSB]}}, label11};
  assign imm_ext    = {{(ADDR_W-IMM8_MSB-1){imm8[IMM8_MSB]}}, imm8};
  assign label_tgt  = pc_plus1 + label_ext;
  assign branch_tgt = pc_plus1 + imm_ext;

  // A JMP without any target flag falls through to the branch / sequential cases.
  always_comb begin
    next_pc = pc_plus1;
    if (jmp && flag_rd_pc) begin
      next_pc = rd_data;
    end else if (jmp && flag_rm_pc) begin
      next_pc = rm_data;
    end else if (jmp && flag_label_pc) begin
      next_pc = label_tgt;
    end else if (branch) begin
      next_pc = branch_tgt;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word per req/ack handshake and presents it for one EXEC cycle.
// Two cycles minimum per instruction; a slow memory simply stretches FETCH, HLT stops fetching until reset.
module instruction_fetch
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [15:0]       NOP_WORD = DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  input  logic              BRANCH,
  input  logic              JMP,
  input  logic              flag_label_PC,
  input  logic              flag_Rm_PC,
  input  logic              flag_Rd_PC,
  input  logic              flag_HLT,
  input  logic [ADDR_W-1:0] rm_data,
  input  logic [ADDR_W-1:0] rd_data,
  output logic              halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus1  = pc_out + ADDR_W'(1);

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_sel (
    .pc_plus1      (pc_plus1),
    .label11       (instr_out[LABEL11_MSB:0]),
    .imm8          (instr_out[IMM8_MSB:0]),
    .branch        (BRANCH),
    .jmp           (JMP),
    .flag_label_pc (flag_label_PC),
    .flag_rm_pc    (flag_Rm_PC),
    .flag_rd_pc    (flag_Rd_PC),
    .rm_data       (rm_data),
    .rd_data       (rd_data),
    .next_pc       (next_pc)
  );

  // Outputs are registered alongside the state so each is already correct on entry to a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= NOP_WORD;
      pc_out      <= RESET_PC;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            state       <= ST_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            instr_out   <= imem_rdata;
            pc_out      <= pc;
          end
        end
        ST_EXEC: begin
          instr_valid <= 1'b0;
          instr_out   <= NOP_WORD;
          // flag_HLT is active-low; halt overrides any redirect but still steps pc for debug.
          if (!flag_HLT) begin
            state  <= ST_HALT;
            pc     <= pc_plus1;
            halted <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            pc       <= next_pc;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: acts as instruction memory and decoder, tracks the expected PC stream
// with a small arithmetic model, and mixes directed redirect cases with randomized instruction traffic.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        BRANCH, JMP, flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_HLT;
  logic [15:0] rm_data, rd_data;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus1(pc_plus1),
    .BRANCH(BRANCH), .JMP(JMP), .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
    .flag_Rd_PC(flag_Rd_PC), .flag_HLT(flag_HLT), .rm_data(rm_data), .rd_data(rd_data),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference next-PC computed directly from the redirect rules with integer offsets.
  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] word,
                                             input bit br, input bit jmp, input bit lab,
                                             input bit rmf, input bit rdf, input bit hltn,
                                             input logic [15:0] rmv, input logic [15:0] rdv);
    int p1, off;
    p1 = int'(pc) + 1;
    if (!hltn) return 16'(p1);
    if (jmp && rdf) return rdv;
    if (jmp && rmf) return rmv;
    if (jmp && lab) begin
      off = int'(word[10:0]);
      if (off >= 1024) off -= 2048;
      return 16'(p1 + off);
    end
    if (br) begin
      off = int'(word[7:0]);
      if (off >= 128) off -= 256;
      return 16'(p1 + off);
    end
    return 16'(p1);
  endfunction

  task automatic clear_ctrl();
    BRANCH = 0; JMP = 0; flag_label_PC = 0; flag_Rm_PC = 0; flag_Rd_PC = 0; flag_HLT = 1;
    rm_data = 16'h0; rd_data = 16'h0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  // One instruction: memory answers after lat cycles, decoder drives the given controls during EXEC.
  task automatic step(input logic [15:0] word, input int lat, input bit br, input bit jmp,
                      input bit lab, input bit rmf, input bit rdf, input bit hltn,
                      input logic [15:0] rmv, input logic [15:0] rdv);
    wait_req();
    chk("fetch_addr", {16'b0, imem_addr}, {16'b0, exp_pc});
    for (int i = 0; i < lat; i++) begin
      imem_ack = 0;
      @(negedge clk);
      chk("wait_req_held", {15'b0, imem_req, instr_valid}, 32'd2);
      chk("wait_addr", {16'b0, imem_addr}, {16'b0, exp_pc});
    end
    imem_ack = 1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 0; imem_rdata = 16'($urandom);
    chk("exec_valid_req", {15'b0, instr_valid, imem_req}, 32'd2);
    chk("instr_out", {16'b0, instr_out}, {16'b0, word});
    chk("pc_out", {16'b0, pc_out}, {16'b0, exp_pc});
    chk("pc_plus1", {16'b0, pc_plus1}, {16'b0, 16'(exp_pc + 16'd1)});
    BRANCH = br; JMP = jmp; flag_label_PC = lab; flag_Rm_PC = rmf; flag_Rd_PC = rdf;
    flag_HLT = hltn; rm_data = rmv; rd_data = rdv;
    exp_pc = model_next(exp_pc, word, br, jmp, lab, rmf, rdf, hltn, rmv, rdv);
    @(negedge clk);
    clear_ctrl();
    chk("post_exec_out", {15'b0, instr_valid, 16'b0}, {15'b0, 1'b0, 16'b0});
    chk("post_exec_nop", {16'b0, instr_out}, 32'h0);
    chk("post_exec_state", {30'b0, halted, imem_req}, hltn ? 32'd1 : 32'd2);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_pc = 16'h0;
  endtask

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 16'h0;
    clear_ctrl();
    do_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", {16'b0, instr_out}, 32'h0);
    chk("rst_pc_out", {16'b0, pc_out}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", {16'b0, imem_addr}, 32'h0);

    // Back-to-back sequential fetches with zero-latency memory.
    step(16'h1000, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    step(16'h1001, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    chk("seq_addr2", {16'b0, imem_addr}, 32'h2);
    // Slow memory.
    step(16'h2222, 3, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    // Backward branch from pc 5.
    step(16'h3333, 0, 0, 1, 0, 0, 1, 1, 16'h0, 16'h0005);
    step(16'h00FC, 1, 1, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    chk("branch_back", {16'b0, imem_addr}, 32'h2);
    // Wrap at the top of the address space.
    step(16'h4444, 0, 0, 1, 0, 0, 1, 1, 16'h0, 16'hFFFF);
    step(16'h5555, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    chk("pc_wrap", {16'b0, imem_addr}, 32'h0);
    // Rd beats Rm; label jump from pc 3.
    step(16'h6666, 0, 0, 1, 1, 1, 1, 1, 16'h0080, 16'h0040);
    chk("rd_over_rm", {16'b0, imem_addr}, 32'h40);
    step(16'h7777, 2, 0, 1, 0, 1, 0, 1, 16'h0003, 16'h0);
    step(16'hF810, 0, 1, 1, 1, 0, 0, 1, 16'h0, 16'h0);
    chk("label_jump", {16'b0, imem_addr}, 32'h14);
    // Target flags without JMP are ignored.
    step(16'h0000, 0, 0, 0, 1, 1, 1, 1, 16'h1234, 16'h5678);
    chk("flags_no_jmp", {16'b0, imem_addr}, 32'h15);

    for (int n = 0; n < 300; n++) begin
      step(16'($urandom), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1,
           16'($urandom), 16'($urandom));
    end

    // Reset colliding with an ack must drop the fetch.
    wait_req();
    imem_ack = 1; imem_rdata = 16'hBEEF; rst = 1;
    @(negedge clk);
    imem_ack = 0; rst = 0; exp_pc = 16'h0;
    chk("rst_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_ack_idle", {31'b0, imem_req}, 32'd0);
    chk("rst_ack_instr", {16'b0, instr_out}, 32'h0);
    @(negedge clk);
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", {16'b0, imem_addr}, 32'h0);

    // HLT together with a branch at pc 7.
    step(16'h8888, 0, 0, 1, 0, 0, 1, 1, 16'h0, 16'h0007);
    step(16'h0010, 1, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("halt_pc", {16'b0, imem_addr}, 32'h8);
    for (int i = 0; i < 20; i++) begin
      imem_ack = bit'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
      @(negedge clk);
      chk("halt_hold", {29'b0, imem_req, instr_valid, halted}, 32'd1);
    end
    imem_ack = 0;
    chk("halt_pc_frozen", {16'b0, imem_addr}, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
